// File: rtl/multiword_sub_seq_pkg.sv
// Shared types and sizing helpers for the nibble-serial subtractor sequencer.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int NIBBLE_W = 4;

  function automatic int nibble_count(input int width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/multiword_sub_seq_if.sv
// Operand/result handshake bundle for multiword_sub_seq.
interface multiword_sub_seq_if #(
  parameter int WIDTH = 16
);

  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             result_valid;
  logic             result_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             busy;

  modport master (
    output start_valid, a, b, bin, result_ready,
    input  start_ready, result_valid, diff, bout, busy
  );

  modport slave (
    input  start_valid, a, b, bin, result_ready,
    output start_ready, result_valid, diff, bout, busy
  );

endinterface

// File: rtl/multiword_sub_seq_nibble_subtractor.sv
// Combinational 4-bit ripple-borrow subtractor slice: d = x - y - cin.
module nibble_subtractor
  import sub_pkg::*;
(
  input  logic [NIBBLE_W-1:0] x,
  input  logic [NIBBLE_W-1:0] y,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] d,
  output logic                cout
);

  logic [NIBBLE_W:0] c_s;

  assign c_s[0] = cin;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_cell
    assign d[i]     = x[i] ^ y[i] ^ c_s[i];
    assign c_s[i+1] = (~x[i] & y[i]) | ((~x[i] | y[i]) & c_s[i]);
  end

  assign cout = c_s[NIBBLE_W];

endmodule

// File: rtl/multiword_sub_seq.sv
// WIDTH-bit a - b - bin computed one nibble per cycle, LSB first, on a single shared slice.
// Define SUB_SAT_EN to clamp an underflowing result to zero (bout still reports the borrow).
module multiword_sub_seq
  import sub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic               clk,
  input logic               rst_n,
  multiword_sub_seq_if.slave bus
);

  localparam int N     = nibble_count(WIDTH);
  localparam int IDX_W = $clog2(N);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               borrow_q, borrow_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               bout_q, bout_d;
  logic               start_ready_q, start_ready_d;
  logic               result_valid_q, result_valid_d;
  logic               busy_q, busy_d;

  logic [NIBBLE_W-1:0] x_s, y_s, d_s;
  logic                cout_s;

  assign x_s = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
  assign y_s = b_q[idx_q*NIBBLE_W +: NIBBLE_W];

  nibble_subtractor u_slice (
    .x    (x_s),
    .y    (y_s),
    .cin  (borrow_q),
    .d    (d_s),
    .cout (cout_s)
  );

  // Next-state, datapath update and state-decoded output flags.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    borrow_d = borrow_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    case (state_q)
      IDLE: begin
        if (bus.start_valid) begin
          a_d      = bus.a;
          b_d      = bus.b;
          borrow_d = bus.bin;
          idx_d    = '0;
          diff_d   = '0;
          state_d  = RUN;
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        diff_d[idx_q*NIBBLE_W +: NIBBLE_W] = d_s;
        borrow_d = cout_s;
        if (idx_q == IDX_W'(N - 1)) begin
          bout_d  = cout_s;
          idx_d   = '0;
          state_d = DONE;
`ifdef SUB_SAT_EN
          // Underflow clamps to zero; the borrow flag still reports it.
          if (cout_s) begin
            diff_d = '0;
          end else begin
            diff_d[idx_q*NIBBLE_W +: NIBBLE_W] = d_s;
          end
`endif
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = RUN;
        end
      end
      DONE: begin
        if (bus.result_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
    start_ready_d  = (state_d == IDLE);
    result_valid_d = (state_d == DONE);
    busy_d         = (state_d != IDLE);
  end

  // State, datapath and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      a_q            <= '0;
      b_q            <= '0;
      borrow_q       <= 1'b0;
      diff_q         <= '0;
      bout_q         <= 1'b0;
      start_ready_q  <= 1'b1;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      a_q            <= a_d;
      b_q            <= b_d;
      borrow_q       <= borrow_d;
      diff_q         <= diff_d;
      bout_q         <= bout_d;
      start_ready_q  <= start_ready_d;
      result_valid_q <= result_valid_d;
      busy_q         <= busy_d;
    end
  end

  assign bus.start_ready  = start_ready_q;
  assign bus.result_valid = result_valid_q;
  assign bus.busy         = busy_q;
  assign bus.diff         = diff_q;
  assign bus.bout         = bout_q;

endmodule

// File: tb/tb_multiword_sub_seq.sv
// Directed table-driven bench for multiword_sub_seq (WIDTH=16), plus back-pressure and mid-RUN reset sequences.
module tb_multiword_sub_seq;

  localparam int WIDTH = 16;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] diff;
    logic        bout;
  } vec_t;

  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   total_cnt;
  vec_t vecs [8];

  multiword_sub_seq_if #(.WIDTH(WIDTH)) bus ();

  multiword_sub_seq #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  function automatic logic [15:0] exp_diff(input logic [15:0] d, input logic bo);
`ifdef SUB_SAT_EN
    return bo ? 16'h0000 : d;
`else
    return d;
`endif
  endfunction

  task automatic wait_result(output int cyc);
    cyc = 0;
    while (!bus.result_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic do_op(input string nm, input logic [15:0] ta, input logic [15:0] tb_v,
                       input logic tbin, input logic [15:0] ed, input logic eb);
    int cyc;
    cyc = 0;
    while (!bus.start_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    bus.a = ta;
    bus.b = tb_v;
    bus.bin = tbin;
    bus.start_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start_valid = 1'b0;
    wait_result(cyc);
    check({nm, "_latency"}, cyc, 32'd4);
    check({nm, "_diff"}, {16'h0, bus.diff}, {16'h0, exp_diff(ed, eb)});
    check({nm, "_bout"}, {31'h0, bus.bout}, {31'h0, eb});
    bus.result_ready = 1'b1;
    @(negedge clk);
    bus.result_ready = 1'b0;
  endtask

  initial begin
    int cyc;
    pass_cnt  = 0;
    total_cnt = 0;
    vecs[0] = '{16'h000F, 16'h0003, 1'b0, 16'h000C, 1'b0};
    vecs[1] = '{16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0};
    vecs[2] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1};
    vecs[3] = '{16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0};
    vecs[5] = '{16'hABCD, 16'h1234, 1'b1, 16'h9998, 1'b0};
    vecs[6] = '{16'h8000, 16'h8001, 1'b0, 16'hFFFF, 1'b1};
    vecs[7] = '{16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0};

    rst_n = 1'b0;
    bus.start_valid  = 1'b0;
    bus.a            = 16'h0;
    bus.b            = 16'h0;
    bus.bin          = 1'b0;
    bus.result_ready = 1'b0;
    #12;
    check("rst_start_ready",  {31'h0, bus.start_ready},  32'd1);
    check("rst_result_valid", {31'h0, bus.result_valid}, 32'd0);
    check("rst_busy",         {31'h0, bus.busy},         32'd0);
    check("rst_diff",         {16'h0, bus.diff},         32'd0);
    check("rst_bout",         {31'h0, bus.bout},         32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].diff, vecs[i].bout);
    end

    // Back-pressure: foreign operands offered throughout RUN and DONE must be ignored.
    bus.a = 16'h000F; bus.b = 16'h0003; bus.bin = 1'b0; bus.start_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.a = 16'h00F0; bus.b = 16'h0010;
    check("bp_run_start_ready", {31'h0, bus.start_ready}, 32'd0);
    check("bp_run_busy",        {31'h0, bus.busy},        32'd1);
    wait_result(cyc);
    check("bp_latency", cyc, 32'd4);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_hold%0d_diff", i),  {16'h0, bus.diff},        32'h000C);
      check($sformatf("bp_hold%0d_bout", i),  {31'h0, bus.bout},        32'd0);
      check($sformatf("bp_hold%0d_ready", i), {31'h0, bus.start_ready}, 32'd0);
      check($sformatf("bp_hold%0d_valid", i), {31'h0, bus.result_valid}, 32'd1);
      @(negedge clk);
    end
    bus.result_ready = 1'b1;
    @(negedge clk);
    bus.result_ready = 1'b0;
    check("bp_idle_valid",       {31'h0, bus.result_valid}, 32'd0);
    check("bp_idle_start_ready", {31'h0, bus.start_ready},  32'd1);
    check("bp_idle_busy",        {31'h0, bus.busy},         32'd0);
    check("bp_idle_diff_kept",   {16'h0, bus.diff},         32'h000C);
    @(negedge clk);
    bus.start_valid = 1'b0;
    check("bp_accept_busy",       {31'h0, bus.busy},        32'd1);
    check("bp_accept_diff_clear", {16'h0, bus.diff},        32'h0000);
    wait_result(cyc);
    check("bp2_latency", cyc, 32'd4);
    check("bp2_diff", {16'h0, bus.diff}, 32'h00E0);
    check("bp2_bout", {31'h0, bus.bout}, 32'd0);
    bus.result_ready = 1'b1;
    @(negedge clk);
    bus.result_ready = 1'b0;

    // Reset while idx=2: partial diff is discarded, outputs go to reset values at once.
    bus.a = 16'h1234; bus.b = 16'h0111; bus.bin = 1'b0; bus.start_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_run_partial_diff", {16'h0, bus.diff}, 32'h0023);
    rst_n = 1'b0;
    #1;
    check("mid_rst_start_ready",  {31'h0, bus.start_ready},  32'd1);
    check("mid_rst_result_valid", {31'h0, bus.result_valid}, 32'd0);
    check("mid_rst_busy",         {31'h0, bus.busy},         32'd0);
    check("mid_rst_diff",         {16'h0, bus.diff},         32'd0);
    check("mid_rst_bout",         {31'h0, bus.bout},         32'd0);
    @(negedge clk);
    @(negedge clk);
    check("mid_rst_no_result", {31'h0, bus.result_valid}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    do_op("post_rst", 16'h0100, 16'h0001, 1'b0, 16'h00FF, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
